// File: rtl/opsel_pkg.sv
// Shared definitions for the operand selector: error fill value, skid states, select width.
// No logic; imported by the selector and its wrapper.
package opsel_pkg;

    // Fill bit replicated across ELEN when a select is out of range.
    localparam logic OPSEL_ERR_DATA = 1'b0;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic int opsel_sel_w(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/opsel_mux_comb.sv
// Purely combinational NUM_IN:1 selector with range-error flag; zero latency.
// No handshake; the caller owns flow control.
module opsel_mux_comb
    import opsel_pkg::*;
#(
    parameter int ELEN   = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = opsel_sel_w(NUM_IN)
) (
    input  logic [NUM_IN*ELEN-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [ELEN-1:0]        sel_data,
    output logic                   sel_err
);

    // Any index that matches no source leaves the error defaults in place.
    always_comb begin
        sel_data = {ELEN{OPSEL_ERR_DATA}};
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*ELEN +: ELEN];
                sel_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_sel_pipe.sv
// Registered N:1 operand selector with valid/ready; 1-cycle latency, 1 beat/cycle.
// Backpressure: in_ready = !out_valid || out_ready; with OPSEL_SKID_EN a 2-entry skid makes in_ready a flop.
module operand_sel_pipe
    import opsel_pkg::*;
#(
    parameter int ELEN   = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = opsel_sel_w(NUM_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN*ELEN-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ELEN-1:0]        out_data,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [ELEN-1:0] mux_data;
    logic            mux_err;
    logic            accept;

    logic [ELEN-1:0] dat_q, dat_d;
    logic            err_q, err_d;
    logic            vld_q, vld_d;

    opsel_mux_comb #(
        .ELEN   (ELEN),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_data (mux_data),
        .sel_err  (mux_err)
    );

    assign out_data  = dat_q;
    assign out_err   = err_q;
    assign out_valid = vld_q;

`ifdef OPSEL_SKID_EN

    skid_state_e     state_q, state_d;
    logic [ELEN-1:0] skd_dat_q, skd_dat_d;
    logic            skd_err_q, skd_err_d;
    logic            rdy_q, rdy_d;

    assign in_ready = rdy_q;
    assign accept   = in_valid && rdy_q;

    // Main register always holds the oldest beat; skid only absorbs the one beat
    // accepted while the consumer stalls, then refills main as soon as main drains.
    always_comb begin
        state_d   = state_q;
        dat_d     = dat_q;
        err_d     = err_q;
        skd_dat_d = skd_dat_q;
        skd_err_d = skd_err_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    dat_d   = mux_data;
                    err_d   = mux_err;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && out_ready) begin
                    dat_d = mux_data;
                    err_d = mux_err;
                end else if (accept) begin
                    skd_dat_d = mux_data;
                    skd_err_d = mux_err;
                    state_d   = SKID_FULL;
                end else if (out_ready) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_ready) begin
                    dat_d   = skd_dat_q;
                    err_d   = skd_err_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        vld_d = (state_d != SKID_EMPTY);
        rdy_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SKID_EMPTY;
            skd_dat_q <= '0;
            skd_err_q <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            skd_dat_q <= skd_dat_d;
            skd_err_q <= skd_err_d;
            rdy_q     <= rdy_d;
        end
    end

`else

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dat_d = dat_q;
        err_d = err_q;
        vld_d = vld_q;
        if (accept) begin
            dat_d = mux_data;
            err_d = mux_err;
            vld_d = 1'b1;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
            err_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            err_q <= err_d;
            vld_q <= vld_d;
        end
    end

endmodule
